// File: rtl/dp_ram_stream_fifo_pkg.sv
// Purpose : shared defaults and pointer/occupancy types for dp_ram_stream_fifo.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package dp_ram_stream_fifo_pkg;

  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_ADDRESS_WIDTH = 4;
  localparam int DEF_DEPTH         = 1 << DEF_ADDRESS_WIDTH;

  // Occupancy needs one extra bit: the array alone can hold DEPTH words, and
  // the output register adds one more, so level ranges 0..DEPTH+1.
  typedef logic [DEF_ADDRESS_WIDTH:0]   level_t;
  typedef logic [DEF_ADDRESS_WIDTH-1:0] ptr_t;

endpackage

// File: rtl/dp_ram_stream_fifo_mem_2p.sv
// Purpose : two-port storage array, port 1 write-only, port 2 read-only.
// Latency : write lands at the clock edge; read data is combinational from raddr_i.
// Backpr. : none; the caller decides when to write.
// Ports   : clk, wr_en_i/waddr_i/wdata_i (write port), raddr_i -> rdata_o (read port).
module fifo_mem_2p #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     wr_en_i,
  input  logic [ADDRESS_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  input  logic [ADDRESS_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0]    rdata_o
);

  // Contents are deliberately not reset; the pointer logic never reads an
  // entry that has not been written since the last reset or flush.
  logic [DATA_WIDTH-1:0] mem_q [1 << ADDRESS_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dp_ram_stream_fifo.sv
// Purpose : stream FIFO over a two-port array with a registered show-ahead head word.
// Latency : a word written into an empty FIFO is on out_data the cycle after the write edge (bypass).
// Backpr. : in_ready drops when the array is full, en is low or clr is high; no same-cycle pop pass-through.
// Ports   : clk/rst_n, en (freeze), clr (flush), in_* (producer handshake),
//           out_* (consumer handshake), level/full/empty (status).
module dp_ram_stream_fifo
  import dp_ram_stream_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DEPTH         = DEF_DEPTH   // must equal 2**ADDRESS_WIDTH; pointers wrap naturally
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clr,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDRESS_WIDTH:0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam logic [ADDRESS_WIDTH:0]   DEPTH_L = DEPTH[ADDRESS_WIDTH:0];
  localparam logic [ADDRESS_WIDTH:0]   CNT_ONE = {{ADDRESS_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDRESS_WIDTH-1:0] PTR_ONE = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDRESS_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDRESS_WIDTH:0]   count_q, count_d;
  logic                     out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
  logic [DATA_WIDTH-1:0]    mem_rdata;

  logic wr, load_ok, load_arr, bypass, arr_wr;

  // rst_n gating keeps in_ready low for the whole reset window even though
  // count is already zero then.
  assign in_ready = rst_n & en & ~clr & (count_q < DEPTH_L);
  assign wr       = in_valid & in_ready;
  assign load_ok  = en & (~out_valid_q | out_ready);
  assign load_arr = load_ok & (count_q != '0);
  // Bypass only when the array is empty, so no older word can be overtaken.
  assign bypass   = load_ok & (count_q == '0) & wr;
  assign arr_wr   = wr & ~bypass;

  fifo_mem_2p #(
    .DATA_WIDTH   (DATA_WIDTH),
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_mem (
    .clk    (clk),
    .wr_en_i(arr_wr),
    .waddr_i(wr_ptr_q),
    .wdata_i(in_data),
    .raddr_i(rd_ptr_q),
    .rdata_o(mem_rdata)
  );

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (clr) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      // load_ok and arr_wr both already include en, so en=0 leaves all state alone.
      if (load_arr) begin
        out_data_d  = mem_rdata;
        out_valid_d = 1'b1;
        rd_ptr_d    = rd_ptr_q + PTR_ONE;
      end else if (bypass) begin
        out_data_d  = in_data;
        out_valid_d = 1'b1;
      end else if (load_ok) begin
        out_valid_d = 1'b0;
      end
      if (arr_wr) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      case ({arr_wr, load_arr})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign level     = count_q + {{ADDRESS_WIDTH{1'b0}}, out_valid_q};
  assign full      = (count_q == DEPTH_L);
  assign empty     = (level == '0);

endmodule

// File: tb/tb_dp_ram_stream_fifo.sv
module tb_dp_ram_stream_fifo;
  import dp_ram_stream_fifo_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, en, clr, in_valid, out_ready;
  logic [7:0] in_data;
  logic       in_ready, out_valid, full, empty;
  logic [7:0] out_data;
  level_t     level;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dp_ram_stream_fifo dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clr      (clr),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .level    (level),
    .full     (full),
    .empty    (empty)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    in_data  = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Array occupancy derived from ports must never exceed the array size.
  always @(negedge clk) begin
    if (rst_n) check("cnt_le_depth", 32'(int'(level) - int'(out_valid) <= 16), 32'd1);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

    // Reset / idle
    repeat (3) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_level", level, 0);
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    tick();
    check("idle_out_valid", out_valid, 0);
    check("idle_empty", empty, 1);
    check("idle_level", level, 0);
    check("idle_in_ready", in_ready, 1);

    // Bypass latency
    push(8'hAB);
    check("byp_out_valid", out_valid, 1);
    check("byp_out_data", out_data, 8'hAB);
    check("byp_level", level, 1);
    check("byp_full", full, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("byp_pop_empty", empty, 1);
    check("byp_pop_valid", out_valid, 0);

    // Fill to full: 1 bypass word + 16 array words
    for (int i = 0; i < 17; i++) begin
      in_data = 8'(i); in_valid = 1'b1;
      #1 check("fill_in_ready", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    check("full_flag", full, 1);
    check("full_level", level, 17);
    check("full_in_ready", in_ready, 0);
    in_data = 8'hFF; in_valid = 1'b1;
    #1 check("ovf_in_ready", in_ready, 0);
    tick();
    in_valid = 1'b0;
    check("ovf_level", level, 17);
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      check("drain_valid", out_valid, 1);
      check("drain_data", out_data, 32'(i));
      tick();
    end
    out_ready = 1'b0;
    check("drain_empty", empty, 1);
    check("drain_level", level, 0);

    // Simultaneous push/pop at array count 5 (level 6); pointers wrap past 15
    for (int i = 0; i < 6; i++) push(8'h20 + 8'(i));
    check("pp_pre_level", level, 6);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 8'h26 + 8'(i);
      check("pp_level", level, 6);
      check("pp_data", out_data, 32'h20 + 32'(i));
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("pp_tail_data", out_data, 32'h34 + 32'(i));
      tick();
    end
    out_ready = 1'b0;
    check("pp_empty", empty, 1);

    // Enable freeze and flush
    for (int i = 0; i < 4; i++) push(8'h40 + 8'(i));
    check("frz_pre_level", level, 4);
    en = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_data = 8'h99;
    for (int i = 0; i < 3; i++) begin
      #1 check("frz_in_ready", in_ready, 0);
      tick();
      check("frz_level", level, 4);
      check("frz_data", out_data, 8'h40);
    end
    en = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    clr = 1'b1;
    #1 check("clr_in_ready", in_ready, 0);
    tick();
    clr = 1'b0;
    check("clr_level", level, 0);
    check("clr_out_valid", out_valid, 0);
    check("clr_empty", empty, 1);
    push(8'hCD);
    check("post_clr_data", out_data, 8'hCD);
    check("post_clr_valid", out_valid, 1);
    check("post_clr_level", level, 1);

    // Async reset mid-operation
    for (int i = 0; i < 8; i++) push(8'h50 + 8'(i));
    check("ar_pre_level", level, 9);
    #2 rst_n = 1'b0;
    #1;
    check("ar_out_valid", out_valid, 0);
    check("ar_level", level, 0);
    check("ar_full", full, 0);
    check("ar_empty", empty, 1);
    #3 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) push(8'h60 + 8'(i));
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("ar_order_valid", out_valid, 1);
      check("ar_order_data", out_data, 32'h60 + 32'(i));
      tick();
    end
    out_ready = 1'b0;
    check("ar_final_empty", empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
